rvc_fetch_aligner: RTL and testbench
====================================

// Module: rvc_fetch_aligner
// PURPOSE
//  Sits between instruction fetch and decode. Buffers 32-bit fetch words as a halfword queue and
//  realigns mixed 16/32-bit streams, including 32-bit instructions that straddle fetch words.
//  Expands RV32C instructions to their RV32I equivalents and emits one instruction per handshake
//  with its PC. Supports pipeline flush/redirect, including redirect to a halfword-aligned PC.
// PARAMETERS
//  HW_DEPTH   8             queue depth in halfwords; power of 2, >=4
//  ENABLE_C   1             1: RV32C expansion on; 0: every instruction is treated as 32-bit
//  RESET_PC   32'h00000000  head PC after reset; bit 0 must be 0
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous active-low reset
//  fetch_valid   in   1   fetch word valid
//  fetch_ready   out  1   aligner can accept a fetch word
//  fetch_data    in   32  fetch word, little-endian halfwords, word-aligned
//  flush         in   1   discard all buffered state, restart at redirect_pc
//  redirect_pc   in   32  new head PC on flush; bit 0 ignored
//  inst_valid    out  1   inst_data/inst_pc valid
//  inst_ready    in   1   decode accepts instruction
//  inst_data     out  32  RV32I instruction (expanded if compressed)
//  inst_pc       out  32  PC of the issued instruction
//  inst_is_c     out  1   issued instruction was 16-bit
//  inst_illegal  out  1   16-bit encoding not supported or reserved
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. Reset state: queue empty (count=0, rd/wr
//    ptr=0), head_pc=RESET_PC, drop_low=RESET_PC[1], fetch_ready=1, inst_valid=0,
//    inst_data/inst_pc=0, inst_is_c=0, inst_illegal=0.
//  - Queue: circular halfword buffer. rd/wr pointers wrap mod HW_DEPTH; count is 0..HW_DEPTH.
//  - fetch_ready = (HW_DEPTH - count) >= 2, evaluated on the registered count before any
//    same-cycle pop. A push occurs on fetch_valid & fetch_ready.
//    Normal push: push fetch_data[15:0] first, then fetch_data[31:16].
//    If drop_low=1: push only fetch_data[31:16], then clear drop_low.
//  - Issue: h0/h1 are the two halfwords at the head. need = 1 if ENABLE_C and h0[1:0]!=2'b11,
//    otherwise 2. inst_valid = (count >= need), combinational from the queue head.
//    Latency: a word pushed in cycle N is issuable in cycle N+1.
//  - inst_valid & inst_ready pops `need` halfwords and sets head_pc += 2*need (mod 2^32).
//    Push and pop may occur in the same cycle; count updates by pushes minus pops.
//  - Output fields:
//    - inst_pc = head_pc; inst_is_c = (need==1).
//    - 32-bit: inst_data = {h1,h0}.
//    - Outputs hold stable while inst_valid & !inst_ready.
//  - Expansion per RV32C spec: C.ADDI4SPN, LW, SW, NOP, ADDI, JAL, LI, ADDI16SP, LUI, SRLI,
//    SRAI, ANDI, SUB, XOR, OR, AND, J, BEQZ, BNEZ, SLLI, LWSP, SWSP, JR, MV, EBREAK, JALR, ADD.
//    - Register primes rd'/rs1'/rs2' map to {2'b01,field}.
//    - Immediates sign-extended where the ISA requires it.
//    - JAL/JALR link register is x1; JR/J link register is x0.
//  - Illegal (inst_illegal=1, inst_data={16'h0,h0}, still pops 1 halfword):
//    - h0==16'h0000;
//    - ADDI4SPN with nzimm=0; LUI/ADDI16SP with imm=0;
//    - LWSP with rd=0; JR with rs1=0;
//    - shift with shamt[5]=1;
//    - any RV64/128 or FP encoding.
//  - flush has priority over all else in its cycle:
//    - count, rd, wr <= 0; head_pc <= {redirect_pc[31:1],1'b0}; drop_low <= redirect_pc[1].
//    - Any same-cycle push or pop is ignored.
//    - inst_valid=0 in the following cycle.
//  - Full queue: fetch_ready=0; buffered data is never overwritten.
//    Empty queue, or a lone 32-bit low half: inst_valid=0.
//  - Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).
// TESTING
//  1. Reset, then hold rst_n low -> fetch_ready=1, inst_valid=0, inst_pc=0; deassert, no input
//     -> unchanged.
//  2. Words 32'h00100093, 32'h00200113 at cycles 0,1; inst_ready=1 -> issue at cycles 1,2,
//     pc 0/4, inst_is_c=0.
//  3. Straddle: words 32'h0093_0001, 32'h0000_0010 ->
//     issue 32'h00000013 pc 0 is_c=1, then 32'h00100093 pc 2 is_c=0.
//  4. Expansion: halfword 16'h12FD (C.ADDI x5,-1) -> inst_data 32'hFFF28293, inst_is_c=1.
//  5. Flush redirect_pc=32'h102, then word 32'h4505_0001 -> only 16'h4505 issued
//     (li x10,1 = 32'h00100513), pc 32'h102; the stale queue is never issued.
//  6. inst_ready=0, stream words until fetch_ready=0 (count=HW_DEPTH);
//     h0=16'h0000 -> inst_illegal=1, pops 1 halfword.
//     Release -> all instructions issued in order, none lost or duplicated.

Source files
------------

// File: rtl/rvc_fetch_aligner.sv
// Fetch-to-decode aligner: halfword queue, 16/32-bit realignment
// and RV32C-to-RV32I expansion with flush/redirect.
module rvc_fetch_aligner #(
  parameter int unsigned HW_DEPTH = 8,
  parameter bit          ENABLE_C = 1'b1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_is_c,
  output logic        inst_illegal
);

  localparam int unsigned AW = $clog2(HW_DEPTH);
  localparam logic [AW:0] LIM = (AW+1)'(HW_DEPTH - 2);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] TWO = (AW+1)'(2);

  logic [HW_DEPTH-1:0][15:0] q;
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW:0]   count;
  logic [31:0]   head_pc;
  logic          drop_low;

  logic [15:0] h0;
  logic [15:0] h1;
  logic        is_c;
  logic [1:0]  need;
  logic        push;
  logic        pop;
  logic [AW:0] push_n;
  logic [AW:0] pop_n;
  logic        unused_ok;

  logic [31:0] exp_data;
  logic        exp_ill;
  logic [4:0]  rdf;
  logic [4:0]  rs2f;
  logic [4:0]  rdp;
  logic [4:0]  rs1p;
  logic [11:0] imm_ci;
  logic [9:0]  imm_4spn;
  logic [6:0]  imm_lw;
  logic [9:0]  imm_16sp;
  logic [7:0]  imm_lwsp;
  logic [7:0]  imm_swsp;
  logic [11:0] imm_j;
  logic [8:0]  imm_b;
  logic [2:0]  alu_f3;
  logic        alu_sub;
  logic [4:0]  link;

  assign unused_ok = redirect_pc[0];

  assign h0   = q[rd];
  assign h1   = q[rd + AW'(1)];
  assign is_c = ENABLE_C && (h0[1:0] != 2'b11);
  assign need = is_c ? 2'd1 : 2'd2;

  assign inst_valid  = count >= {{(AW-1){1'b0}}, need};
  assign fetch_ready = count <= LIM;
  assign push = fetch_valid & fetch_ready;
  assign pop  = inst_valid & inst_ready;

  assign push_n = !push ? '0 : (drop_low ? ONE : TWO);
  assign pop_n  = !pop ? '0 : (is_c ? ONE : TWO);

  assign rdf  = h0[11:7];
  assign rs2f = h0[6:2];
  assign rdp  = {2'b01, h0[4:2]};
  assign rs1p = {2'b01, h0[9:7]};

  assign imm_ci   = {{6{h0[12]}}, h0[12], h0[6:2]};
  assign imm_4spn = {h0[10:7], h0[12:11], h0[5], h0[6], 2'b00};
  assign imm_lw   = {h0[5], h0[12:10], h0[6], 2'b00};
  assign imm_16sp = {h0[12], h0[4:3], h0[5], h0[2], h0[6], 4'b0000};
  assign imm_lwsp = {h0[3:2], h0[12], h0[6:4], 2'b00};
  assign imm_swsp = {h0[8:7], h0[12:9], 2'b00};
  assign imm_j    = {h0[12], h0[8], h0[10:9], h0[6], h0[7],
                     h0[2], h0[11], h0[5:3], 1'b0};
  assign imm_b    = {h0[12], h0[6:5], h0[2], h0[11:10], h0[4:3], 1'b0};
  assign alu_f3   = {|h0[6:5], h0[6], &h0[6:5]};
  assign alu_sub  = (h0[6:5] == 2'b00);
  assign link     = {4'b0000, ~h0[15]};

  // Expand the head halfword into its 32-bit equivalent.
  always_comb begin
    exp_data = 32'h0;
    exp_ill  = 1'b0;
    unique case (h0[1:0])
      2'b00: begin
        unique case (h0[15:13])
          3'b000: begin
            exp_data = {2'b00, imm_4spn, 5'd2, 3'b000, rdp, 7'h13};
            exp_ill  = (imm_4spn == 10'd0);
          end
          3'b010:
            exp_data = {5'b0, imm_lw, rs1p, 3'b010, rdp, 7'h03};
          3'b110:
            exp_data = {5'b0, imm_lw[6:5], rdp, rs1p, 3'b010,
                        imm_lw[4:0], 7'h23};
          default: exp_ill = 1'b1;
        endcase
      end
      2'b01: begin
        unique case (h0[15:13])
          3'b000:
            exp_data = {imm_ci, rdf, 3'b000, rdf, 7'h13};
          3'b001, 3'b101:
            exp_data = {imm_j[11], imm_j[10:1], imm_j[11],
                        {8{imm_j[11]}}, link, 7'h6f};
          3'b010:
            exp_data = {imm_ci, 5'd0, 3'b000, rdf, 7'h13};
          3'b011: begin
            if (rdf == 5'd2) begin
              exp_data = {{2{imm_16sp[9]}}, imm_16sp, 5'd2,
                          3'b000, 5'd2, 7'h13};
              exp_ill  = (imm_16sp == 10'd0);
            end else begin
              exp_data = {{14{h0[12]}}, h0[12], h0[6:2], rdf, 7'h37};
              exp_ill  = ({h0[12], h0[6:2]} == 6'd0);
            end
          end
          3'b100: begin
            unique case (h0[11:10])
              2'b00, 2'b01: begin
                exp_data = {1'b0, h0[10], 5'b0, h0[6:2], rs1p,
                            3'b101, rs1p, 7'h13};
                exp_ill  = h0[12];
              end
              2'b10:
                exp_data = {imm_ci, rs1p, 3'b111, rs1p, 7'h13};
              default: begin
                exp_data = {1'b0, alu_sub, 5'b0, rdp, rs1p,
                            alu_f3, rs1p, 7'h33};
                exp_ill  = h0[12];
              end
            endcase
          end
          default:
            exp_data = {{4{imm_b[8]}}, imm_b[7:5], 5'd0, rs1p,
                        {2'b00, h0[13]}, imm_b[4:1], imm_b[8], 7'h63};
        endcase
      end
      2'b10: begin
        unique case (h0[15:13])
          3'b000: begin
            exp_data = {7'b0, h0[6:2], rdf, 3'b001, rdf, 7'h13};
            exp_ill  = h0[12];
          end
          3'b010: begin
            exp_data = {4'b0, imm_lwsp, 5'd2, 3'b010, rdf, 7'h03};
            exp_ill  = (rdf == 5'd0);
          end
          3'b100: begin
            if (!h0[12]) begin
              if (rs2f == 5'd0) begin
                exp_data = {12'h0, rdf, 3'b000, 5'd0, 7'h67};
                exp_ill  = (rdf == 5'd0);
              end else begin
                exp_data = {7'b0, rs2f, 5'd0, 3'b000, rdf, 7'h33};
              end
            end else if (rs2f == 5'd0) begin
              if (rdf == 5'd0) exp_data = 32'h0010_0073;
              else exp_data = {12'h0, rdf, 3'b000, 5'd1, 7'h67};
            end else begin
              exp_data = {7'b0, rs2f, rdf, 3'b000, rdf, 7'h33};
            end
          end
          3'b110:
            exp_data = {4'b0, imm_swsp[7:5], rs2f, 5'd2, 3'b010,
                        imm_swsp[4:0], 7'h23};
          default: exp_ill = 1'b1;
        endcase
      end
      default: exp_ill = 1'b1;
    endcase
    if (h0 == 16'h0000) exp_ill = 1'b1;
  end

  assign inst_pc      = head_pc;
  assign inst_is_c    = inst_valid & is_c;
  assign inst_illegal = inst_valid & is_c & exp_ill;
  assign inst_data    = !inst_valid ? 32'h0 :
                        !is_c       ? {h1, h0} :
                        exp_ill     ? {16'h0, h0} : exp_data;

  // Queue storage, pointers, occupancy and head PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      rd       <= '0;
      wr       <= '0;
      count    <= '0;
      head_pc  <= RESET_PC;
      drop_low <= RESET_PC[1];
    end else if (flush) begin
      rd       <= '0;
      wr       <= '0;
      count    <= '0;
      head_pc  <= {redirect_pc[31:1], 1'b0};
      drop_low <= redirect_pc[1];
    end else begin
      if (push) begin
        if (drop_low) begin
          q[wr]    <= fetch_data[31:16];
          wr       <= wr + AW'(1);
          drop_low <= 1'b0;
        end else begin
          q[wr]          <= fetch_data[15:0];
          q[wr + AW'(1)] <= fetch_data[31:16];
          wr             <= wr + AW'(2);
        end
      end
      if (pop) begin
        rd      <= rd + (is_c ? AW'(1) : AW'(2));
        head_pc <= head_pc + (is_c ? 32'd2 : 32'd4);
      end
      count <= count + push_n - pop_n;
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Scoreboard bench for rvc_fetch_aligner.
// Directed words; monitor pops expected issues.
module tb_rvc_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_data = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_c;
  logic        inst_illegal;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        is_c;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] epc = 32'h0;

  rvc_fetch_aligner #(
    .HW_DEPTH(8),
    .ENABLE_C(1'b1),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_data(fetch_data),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc),
    .inst_is_c(inst_is_c),
    .inst_illegal(inst_illegal)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit hit, want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic exp_c(input logic [31:0] d, input logic ill);
    sb.push_back('{d, epc, 1'b1, ill});
    epc = epc + 32'd2;
  endtask

  task automatic exp_w(input logic [31:0] d);
    sb.push_back('{d, epc, 1'b0, 1'b0});
    epc = epc + 32'd4;
  endtask

  task automatic push(input logic [31:0] w);
    int n = 0;
    fetch_valid = 1'b1;
    fetch_data  = w;
    @(negedge clk);
    while (!fetch_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!fetch_ready) begin
      total++;
      bad++;
      $display("FAIL push_wait: fetch_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush       = 1'b1;
    redirect_pc = pc;
    fetch_valid = 1'b1;
    fetch_data  = 32'hDEAD_0001;
    @(posedge clk);
    #1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    epc         = {pc[31:1], 1'b0};
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d left want 0", sb.size());
    end
    @(posedge clk);
    #1;
    check("idle_valid", {31'h0, inst_valid}, 32'h0);
  endtask

  // Monitor: compare each handshake against the scoreboard head.
  initial begin : mon
    exp_t        e;
    logic        stall_q;
    logic [65:0] out_q;
    logic [65:0] cur;
    stall_q = 1'b0;
    out_q   = '0;
    forever begin
      @(negedge clk);
      cur = {inst_data, inst_pc, inst_is_c, inst_illegal};
      if (rst_n && stall_q && inst_valid) begin
        total++;
        if (cur !== out_q) begin
          bad++;
          $display("FAIL hold: got %h want %h", cur, out_q);
        end
      end
      if (rst_n && !flush && inst_valid && inst_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_issue: got data=%h pc=%h want none",
                   inst_data, inst_pc);
        end else begin
          e = sb.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL issue: got d=%h pc=%h c=%b il=%b want d=%h pc=%h c=%b il=%b",
                     inst_data, inst_pc, inst_is_c, inst_illegal,
                     e.data, e.pc, e.is_c, e.ill);
          end
        end
      end
      stall_q = rst_n && !flush && inst_valid && !inst_ready;
      out_q   = cur;
    end
  end

  initial begin
    // reset held
    repeat (2) @(posedge clk);
    #1;
    check("rst_fready", {31'h0, fetch_ready}, 32'h1);
    check("rst_ivalid", {31'h0, inst_valid}, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_data", inst_data, 32'h0);
    check("rst_isc", {31'h0, inst_is_c}, 32'h0);
    check("rst_ill", {31'h0, inst_illegal}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_fready", {31'h0, fetch_ready}, 32'h1);
    check("idle_ivalid", {31'h0, inst_valid}, 32'h0);
    check("idle_pc", inst_pc, 32'h0);

    // back-to-back 32-bit words
    inst_ready = 1'b1;
    epc = 32'h0;
    exp_w(32'h0010_0093);
    exp_w(32'h0020_0113);
    push(32'h0010_0093);
    check("latency_valid", {31'h0, inst_valid}, 32'h1);
    push(32'h0020_0113);
    drain();

    // straddling 32-bit instruction
    do_flush(32'h0);
    check("post_flush_valid", {31'h0, inst_valid}, 32'h0);
    exp_c(32'h0000_0013, 1'b0);
    exp_w(32'h0010_0093);
    exp_c(32'h0000_0000, 1'b1);
    push(32'h0093_0001);
    push(32'h0000_0010);
    drain();

    // expansion vectors
    do_flush(32'h0);
    exp_c(32'hFFF2_8293, 1'b0);
    exp_c(32'h0000_0013, 1'b0);
    exp_c(32'h0044_A403, 1'b0);
    exp_c(32'hFFFF_F06F, 1'b0);
    exp_c(32'h00B0_0533, 1'b0);
    exp_c(32'h4094_0433, 1'b0);
    exp_c(32'h0010_0073, 1'b0);
    exp_c(32'h0000_1286, 1'b1);
    exp_c(32'h0000_4002, 1'b1);
    exp_c(32'h0004_0463, 1'b0);
    push(32'h0001_12FD);
    push(32'hBFFD_40C0);
    push(32'h8C05_852E);
    push(32'h1286_9002);
    push(32'hC401_4002);
    drain();

    // stale queue then halfword redirect
    inst_ready = 1'b0;
    push(32'h0001_0001);
    do_flush(32'h0000_0102);
    check("redir_valid", {31'h0, inst_valid}, 32'h0);
    check("redir_pc", inst_pc, 32'h0000_0102);
    inst_ready = 1'b1;
    exp_c(32'h0010_0513, 1'b0);
    push(32'h4505_0001);
    exp_c(32'h0000_0013, 1'b0);
    exp_c(32'h0000_0013, 1'b0);
    push(32'h0001_0001);
    drain();

    // fill to full with decode stalled, then release
    do_flush(32'h0000_0200);
    inst_ready = 1'b0;
    exp_c(32'hFFF2_8293, 1'b0);
    exp_c(32'h0000_0000, 1'b1);
    exp_w(32'h0010_0093);
    exp_c(32'h0010_0513, 1'b0);
    exp_w(32'h0020_0113);
    exp_c(32'h0000_0013, 1'b0);
    exp_c(32'h0000_0013, 1'b0);
    exp_c(32'h0000_0013, 1'b0);
    push(32'h0000_12FD);
    push(32'h0010_0093);
    push(32'h0113_4505);
    push(32'h0001_0020);
    check("full_fready", {31'h0, fetch_ready}, 32'h0);
    check("full_valid", {31'h0, inst_valid}, 32'h1);
    check("full_head", inst_data, 32'hFFF2_8293);
    check("full_pc", inst_pc, 32'h0000_0200);
    fork
      push(32'h0001_0001);
      begin
        repeat (3) @(posedge clk);
        #1;
        inst_ready = 1'b1;
      end
    join
    drain();

    // asynchronous reset mid-operation
    inst_ready = 1'b0;
    push(32'h0001_0001);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, inst_valid}, 32'h0);
    check("mid_rst_fready", {31'h0, fetch_ready}, 32'h1);
    check("mid_rst_pc", inst_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'h0, inst_valid}, 32'h0);
    epc = 32'h0;
    inst_ready = 1'b1;
    exp_c(32'hFFF2_8293, 1'b0);
    exp_c(32'h0000_0013, 1'b0);
    push(32'h0001_12FD);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
